// File: rtl/am_insert_tx.sv
// 40GBASE-R TX alignment marker insertion: forwards 66b blocks on all lanes in lockstep,
// inserts one lane-specific AM every AM_GAP data blocks and maintains per-lane BIP3.
module am_insert_tx #(
    parameter int LANE_N  = 4,
    parameter int HEAD_W  = 2,
    parameter int DATA_W  = 64,
    parameter int BLOCK_W = HEAD_W + DATA_W,
    parameter int AM_GAP  = 16383
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [LANE_N*BLOCK_W-1:0] block_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      am_v_o,
    output logic [LANE_N*BLOCK_W-1:0] block_o
);

    localparam int               CNT_W    = $clog2(AM_GAP + 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(AM_GAP);

    logic                      r_valid;
    logic                      r_am_v;
    logic                      r_am_due;
    logic [CNT_W-1:0]          r_cnt;
    logic [LANE_N*BLOCK_W-1:0] r_block;
    logic [7:0]                r_bip [LANE_N];

    logic                      w_load;
    logic [CNT_W-1:0]          w_cnt_inc;
    logic [LANE_N*BLOCK_W-1:0] w_am_all;
    logic [7:0]                w_am_bip [LANE_N];
    logic [7:0]                w_in_bip [LANE_N];

    // Header bit 0 feeds BIP bit 3, header bit 1 feeds BIP bit 4; payload bits fold bytewise.
    function automatic logic [7:0] bip_fold(input logic [BLOCK_W-1:0] b);
        logic [7:0]        f;
        logic [DATA_W-1:0] d;
        f = '0;
        d = b[BLOCK_W-1:HEAD_W];
        for (int i = 0; i < DATA_W / 8; i++) begin
            f = f ^ d[8*i +: 8];
        end
        f[3] = f[3] ^ b[0];
        f[4] = f[4] ^ b[1];
        return f;
    endfunction

    function automatic logic [BLOCK_W-1:0] am_block(input int lane, input logic [7:0] bip);
        logic [23:0]       m;
        logic [DATA_W-1:0] d;
        case (lane)
            0:       m = 24'h47_76_90;
            1:       m = 24'hE6_C4_F0;
            2:       m = 24'h9B_65_C5;
            3:       m = 24'h3D_79_A2;
            default: m = 24'h00_00_00;
        endcase
        d = DATA_W'({~bip, ~m, bip, m});
        return {d, HEAD_W'(2'b01)};
    endfunction

    assign w_load    = ~r_valid | ready_i;
    assign ready_o   = w_load & ~r_am_due;
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    always_comb begin
        w_am_all = '0;
        for (int l = 0; l < LANE_N; l++) begin
            w_am_all[l*BLOCK_W +: BLOCK_W] = am_block(l, r_bip[l]);
            w_am_bip[l] = bip_fold(w_am_all[l*BLOCK_W +: BLOCK_W]);
            w_in_bip[l] = r_bip[l] ^ bip_fold(block_i[l*BLOCK_W +: BLOCK_W]);
        end
    end

    // An AM restarts the BIP with its own fold; its BIP3 field carries the previous interval.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_valid  <= 1'b0;
            r_am_v   <= 1'b0;
            r_am_due <= 1'b1;
            r_cnt    <= '0;
            r_block  <= '0;
            for (int l = 0; l < LANE_N; l++) begin
                r_bip[l] <= '0;
            end
        end else if (w_load) begin
            if (r_am_due) begin
                r_valid  <= 1'b1;
                r_am_v   <= 1'b1;
                r_am_due <= 1'b0;
                r_cnt    <= '0;
                r_block  <= w_am_all;
                for (int l = 0; l < LANE_N; l++) begin
                    r_bip[l] <= w_am_bip[l];
                end
            end else if (valid_i) begin
                r_valid  <= 1'b1;
                r_am_v   <= 1'b0;
                r_am_due <= (w_cnt_inc == GAP_LAST);
                r_cnt    <= w_cnt_inc;
                r_block  <= block_i;
                for (int l = 0; l < LANE_N; l++) begin
                    r_bip[l] <= w_in_bip[l];
                end
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign valid_o = r_valid;
    assign am_v_o  = r_am_v;
    assign block_o = r_block;

endmodule

// File: tb/tb_am_insert_tx.sv
// Scoreboard bench for am_insert_tx: accepted input blocks are queued, and a stream-level
// reference model predicts AM placement, BIP3 contents and ready_o on every cycle.
module tb_am_insert_tx;

    localparam int LN  = 4;
    localparam int BW  = 66;
    localparam int GAP = 4;
    localparam int TW  = LN * BW;

    logic          clk     = 1'b0;
    logic          nreset  = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_i = 1'b0;
    logic [TW-1:0] block_i = '0;
    logic          ready_o;
    logic          valid_o;
    logic          am_v_o;
    logic [TW-1:0] block_o;

    int            nvec = 0;
    int            errs = 0;
    int            seq  = 0;
    logic [TW-1:0] blk;

    // Reference model state: items already handed to the gearbox.
    logic [7:0]    m_bip [LN];
    int            m_c;
    bit            m_first;
    logic [TW-1:0] q[$];

    am_insert_tx #(
        .LANE_N (LN),
        .HEAD_W (2),
        .DATA_W (64),
        .BLOCK_W(BW),
        .AM_GAP (GAP)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .block_i(block_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .am_v_o (am_v_o),
        .block_o(block_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] fold(input logic [65:0] b);
        logic [7:0]  f;
        logic [63:0] d;
        f = 8'h00;
        d = b[65:2];
        for (int i = 0; i < 8; i++) begin
            f = f ^ d[7:0];
            d = d >> 8;
        end
        f[3] = f[3] ^ b[0];
        f[4] = f[4] ^ b[1];
        return f;
    endfunction

    function automatic logic [65:0] am_ref(input int lane, input logic [7:0] bip);
        logic [7:0]  by [8];
        logic [63:0] d;
        case (lane)
            0:       begin by[0] = 8'h90; by[1] = 8'h76; by[2] = 8'h47; end
            1:       begin by[0] = 8'hF0; by[1] = 8'hC4; by[2] = 8'hE6; end
            2:       begin by[0] = 8'hC5; by[1] = 8'h65; by[2] = 8'h9B; end
            default: begin by[0] = 8'hA2; by[1] = 8'h79; by[2] = 8'h3D; end
        endcase
        by[3] = bip;
        for (int i = 0; i < 4; i++) by[4+i] = ~by[i];
        d = '0;
        for (int i = 0; i < 8; i++) d[8*i +: 8] = by[i];
        return {d, 2'b01};
    endfunction

    function automatic logic [TW-1:0] rnd_block();
        logic [TW-1:0] b;
        for (int l = 0; l < LN; l++) begin
            b[l*BW +: BW] = {$urandom(), 32'(seq * 4 + l), ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10};
        end
        seq++;
        return b;
    endfunction

    function automatic logic [TW-1:0] zero_block();
        logic [TW-1:0] b;
        for (int l = 0; l < LN; l++) b[l*BW +: BW] = {64'h0, 2'b10};
        return b;
    endfunction

    task automatic chk(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_first = 1'b1;
        m_c     = 0;
        for (int l = 0; l < LN; l++) m_bip[l] = 8'h00;
        q.delete();
    endtask

    // One cycle of stimulus; a fresh block is generated once the pending one was taken.
    task automatic cyc(input bit v, input bit r, input bit z);
        bit acc;
        @(negedge clk);
        acc = valid_i && ready_o;
        @(posedge clk);
        #1;
        if (acc || !valid_i) blk = z ? zero_block() : rnd_block();
        valid_i = v;
        ready_i = r;
        block_i = blk;
    endtask

    // Input side of the scoreboard: every accepted block is expected downstream in order.
    initial begin : in_mon
        forever begin
            @(negedge clk);
            if (nreset && valid_i && ready_o) q.push_back(block_i);
        end
    end

    // Output side: predict the held item, check it every cycle, retire it on transfer.
    initial begin : out_mon
        bit            is_am;
        bit            nxt_am;
        bit            have;
        logic [TW-1:0] e;
        forever begin
            @(negedge clk);
            if (nreset) begin
                is_am = m_first || (m_c == GAP);
                have  = 1'b1;
                e     = '0;
                if (is_am) begin
                    for (int l = 0; l < LN; l++) e[l*BW +: BW] = am_ref(l, m_bip[l]);
                end else if (q.size() == 0) begin
                    have = 1'b0;
                end else begin
                    e = q[0];
                end
                if (valid_o) begin
                    if (!have) begin
                        nvec++;
                        errs++;
                        $display("FAIL unexpected_data: got %h expected none pending", block_o);
                    end else begin
                        chk("block_o", block_o, e);
                        chk("am_v_o", TW'(am_v_o), TW'(is_am));
                    end
                end
                nxt_am = valid_o ? (!is_am && (m_c + 1 == GAP)) : is_am;
                chk("ready_o", TW'(ready_o), TW'((!valid_o || ready_i) && !nxt_am));
                if (valid_o && ready_i && have) begin
                    if (is_am) begin
                        for (int l = 0; l < LN; l++) m_bip[l] = fold(e[l*BW +: BW]);
                        m_c     = 0;
                        m_first = 1'b0;
                    end else begin
                        for (int l = 0; l < LN; l++) m_bip[l] = m_bip[l] ^ fold(e[l*BW +: BW]);
                        void'(q.pop_front());
                        m_c++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int n;
        model_reset();
        blk     = rnd_block();
        block_i = blk;
        valid_i = 1'b1;
        ready_i = 1'b1;
        #12;
        chk("ready_o_in_reset", TW'(ready_o), '0);
        chk("valid_o_in_reset", TW'(valid_o), '0);
        chk("block_o_in_reset", block_o, '0);
        nreset = 1'b1;
        @(posedge clk);
        #1;
        chk("first_am_lane0", TW'(block_o[65:2]), TW'(64'hFFB8_896F_0047_7690));
        chk("first_am_flag", TW'(am_v_o), TW'(1'b1));

        repeat (30) cyc(1'b1, 1'b1, 1'b0);
        repeat (12) cyc(1'b1, 1'b1, 1'b1);
        repeat (200) cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'b0);

        // Hold an AM, then a data block, on the output for five cycles.
        n = 0;
        while (!(valid_o && am_v_o) && n < 20) begin
            cyc(1'b1, 1'b1, 1'b0);
            n++;
        end
        repeat (5) cyc(1'b1, 1'b0, 1'b0);
        repeat (2) cyc(1'b1, 1'b1, 1'b0);
        repeat (5) cyc(1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            cyc(1'b0, 1'b1, 1'b0);
            cyc(1'b0, 1'b1, 1'b0);
        end

        // Asynchronous reset in the middle of a gap.
        repeat (6) cyc(1'b1, 1'b1, 1'b0);
        #2;
        nreset = 1'b0;
        #1;
        chk("valid_o_async_clr", TW'(valid_o), '0);
        chk("am_v_o_async_clr", TW'(am_v_o), '0);
        chk("block_o_async_clr", block_o, '0);
        model_reset();
        @(posedge clk);
        #3;
        nreset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_am", TW'(am_v_o), TW'(1'b1));
        chk("post_reset_bip3", TW'(block_o[33:26]), '0);

        repeat (150) cyc($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, 1'b0);

        n = 0;
        while ((q.size() != 0 || valid_o) && n < 40) begin
            cyc(1'b0, 1'b1, 1'b0);
            n++;
        end
        repeat (2) cyc(1'b0, 1'b1, 1'b0);
        chk("drain_empty", TW'(q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule
